// File: rtl/encoder16x4_arb.sv
// ----------------------------------------------------------------------------
// encoder16x4_arb
//
// Sequential 16-to-4 request encoder. Rising edges on the 16 request lines are
// captured into a sticky pending register. One pending line at a time is
// offered as a 4-bit code with a valid/ready handshake, and that line is
// cleared once the consumer accepts the code.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   en           in   1   allows new offers (an offer in progress is not retracted)
//   req          in  16   request lines, bit i is line Di
//   code         out  4   index of the offered line
//   valid        out  1   code is being offered
//   ready        in   1   consumer accepts when valid && ready at a rising edge
//   pending      out 16   sticky pending register
//   any_pending  out  1   OR of pending (registered)
//
// Build option:
//   ENCODER_RR_EN  when defined, selection is round-robin starting at a pointer
//                  that moves to one past each accepted code. When undefined,
//                  selection is fixed priority with D0 highest.
// ----------------------------------------------------------------------------
module encoder16x4_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] req,
    output logic [3:0]  code,
    output logic        valid,
    input  logic        ready,
    output logic [15:0] pending,
    output logic        any_pending
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] req_q;
    logic [15:0] pending_q, pending_d;
    logic [3:0]  code_q, code_d;
    logic        any_pending_q;

    logic [15:0] rise;
    logic [15:0] clr;
    logic [3:0]  sel_code;

    assign rise = req & ~req_q;

`ifdef ENCODER_RR_EN
    logic [3:0] ptr_q, ptr_d;

    // Walk from the pointer upward with wrap-around. Iterating the offset
    // from high to low lets the smallest offset overwrite the result last.
    always_comb begin
        logic [3:0] idx;
        sel_code = 4'd0;
        idx      = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            idx = ptr_q + 4'(k);
            if (pending_q[idx]) begin
                sel_code = idx;
            end
        end
    end
`else
    // Fixed priority: scan downward so the lowest set index is written last.
    always_comb begin
        sel_code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_code = 4'(i);
            end
        end
    end
`endif

    // Handshake FSM. The offered code is latched on entry to OFFER so it
    // stays stable under backpressure even if pending changes meanwhile.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        clr     = 16'd0;
`ifdef ENCODER_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (en && (pending_q != 16'd0)) begin
                    state_d = OFFER;
                    code_d  = sel_code;
                end
            end
            OFFER: begin
                if (ready) begin
                    state_d = IDLE;
                    clr     = 16'd1 << code_q;
`ifdef ENCODER_RR_EN
                    ptr_d   = code_q + 4'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        // A rise landing on the accept edge re-arms the same line.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_q         <= 16'd0;
            pending_q     <= 16'd0;
            code_q        <= 4'd0;
            any_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req;
            pending_q     <= pending_d;
            code_q        <= code_d;
            any_pending_q <= |pending_d;
        end
    end

`ifdef ENCODER_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 4'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign code        = code_q;
    assign valid       = (state_q == OFFER);
    assign pending     = pending_q;
    assign any_pending = any_pending_q;

endmodule
